multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath built around the MainExp32 ALU.
- Sequences fetch/decode/execute/memory/writeback over multiple cycles and drives the ALU's 2-bit ALUop: 00 = add, 01 = sub, 10 = R-type (funct decoded inside the ALU).
- Waits on a memory-ready handshake, times out stalled accesses, and traps illegal opcodes.

Parameters:
- MEM_TIMEOUT, 15: max consecutive MemReady=0 cycles in a memory state before a fault; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  opcode from the instruction register.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if the ALU Zero output is set.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data is MDR (1) or ALUOut (0).
- RegDst  out  1  destination register is rd (1) or rt (0).
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = RD1.
- ALUSrcB  out  2  00 = RD2, 01 = const 4, 10 = SE, 11 = SE<<2.
- ALUop  out  2  to the ALU.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- State  out  4  current state code, for debug.
- FaultCode  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, FAULT 15.
- Reset (async): State=FETCH, wait counter=0, FaultCode=00.
  - Outputs take FETCH values: MemRead=1, IRWrite=PCWrite=MemReady, all other outputs 0.
  - Reset mid-operation abandons the instruction; MemWrite/RegWrite drop immediately.
- Outputs are decoded from the state only, except IRWrite/PCWrite in FETCH, which equal MemReady. Any signal not listed for a state is 0.
- Per-state outputs and next state:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. MemReady=1 -> DECODE, else stay.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target). Next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDI_EX
    - any other Op -> FAULT, FaultCode=01
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MEM_READ, sw -> MEM_WRITE (Op held stable by the IR).
  - MEM_READ: MemRead=1, IorD=1. MemReady -> MEM_WB, else stay.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. MemReady -> FETCH, else stay.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUop=10 -> ALU_WB.
  - ALU_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUop=00 -> ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
  - FAULT: all control outputs 0; sticky until reset; FaultCode holds its value.
- Latencies with zero wait states: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Wait counter (memory states FETCH, MEM_READ, MEM_WRITE only):
  - Increments each cycle MemReady=0; clears on any state change.
  - If counter==MEM_TIMEOUT and MemReady=0 -> FAULT, FaultCode=10.
  - MemReady=1 in the timeout cycle wins: normal transition, no fault.
  - Counter saturates and never wraps; with MEM_TIMEOUT=0 it holds at 0 and never faults.
- FaultCode is written only on entry to FAULT.

Test Plan:
- Reset, then MemReady=1 always, Op=000000 -> states 0,1,6,7,0. EXECUTE has ALUop=10, ALUSrcB=00; ALU_WB has RegWrite=1, RegDst=1. Exactly 4 cycles.
- Op=100011, MemReady low 3 cycles in MEM_READ -> 0,1,2,3,3,3,3,4,0. MemRead=IorD=1 throughout MEM_READ; MEM_WB has MemtoReg=1, RegWrite=1.
- Op=000100 then Op=000010 -> BRANCH has ALUop=01, PCWriteCond=1, PCSource=01; JUMP has PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- Op=111111 -> FAULT (State=15), FaultCode=01, all controls 0 for 20 cycles; reset returns to State=0, FaultCode=00.
- MEM_TIMEOUT=15, MemReady=0 held in FETCH -> FAULT after 16 cycles with FaultCode=10. Repeat with MemReady=1 on the 16th cycle -> DECODE, no fault.
- Op=101011, assert reset while in MEM_WRITE with MemReady=0 -> MemWrite drops to 0 immediately, State=0; after release, a normal fetch follows.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction over
// several cycles, waits on the memory handshake, times out stalls and traps bad opcodes.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic [1:0] FaultCode
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FAULT_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_FAULT     = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [FAULT_W-1:0] FC_NONE    = 2'b00;
  localparam logic [FAULT_W-1:0] FC_ILLEGAL = 2'b01;
  localparam logic [FAULT_W-1:0] FC_TIMEOUT = 2'b10;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic             TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_next_cnt;
  logic [FAULT_W-1:0]   r_fault;
  logic [FAULT_W-1:0]   w_next_fault;
  ctrl_t                r_ctrl;
  logic                 w_mem_state;
  logic                 w_timeout;
  logic                 w_fetch_grant;

  // Moore control word for a given state; FETCH's IRWrite/PCWrite are added separately.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEM_ADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEM_READ: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEM_WB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALU_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      S_ADDI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDI_WB: c.regwrite = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Memory-wait timeout detection
  always_comb begin
    w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    w_timeout   = TIMEOUT_EN && w_mem_state && !MemReady && (r_cnt == TIMEOUT_CNT);
  end

  // Next state and fault code; a timeout overrides the stay-in-state decision.
  always_comb begin
    w_next_state = r_state;
    w_next_fault = r_fault;
    case (r_state)
      S_FETCH:     if (MemReady) w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDI_EX;
          default: begin
            w_next_state = S_FAULT;
            w_next_fault = FC_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR:  w_next_state = (Op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (MemReady) w_next_state = S_MEM_WB;
      S_MEM_WB:    w_next_state = S_FETCH;
      S_MEM_WRITE: if (MemReady) w_next_state = S_FETCH;
      S_EXECUTE:   w_next_state = S_ALU_WB;
      S_ALU_WB:    w_next_state = S_FETCH;
      S_BRANCH:    w_next_state = S_FETCH;
      S_JUMP:      w_next_state = S_FETCH;
      S_ADDI_EX:   w_next_state = S_ADDI_WB;
      S_ADDI_WB:   w_next_state = S_FETCH;
      S_FAULT:     w_next_state = S_FAULT;
      default:     w_next_state = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next_state = S_FAULT;
      w_next_fault = FC_TIMEOUT;
    end
  end

  // Wait counter: counts stalled cycles in a memory state, saturating, cleared on state change.
  always_comb begin
    w_next_cnt = '0;
    if (w_mem_state && (w_next_state == r_state)) begin
      w_next_cnt = r_cnt;
      if (!MemReady && TIMEOUT_EN && (r_cnt != '1)) begin
        w_next_cnt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_fault <= FC_NONE;
      r_ctrl  <= decode_ctrl(S_FETCH);
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_fault <= w_next_fault;
      r_ctrl  <= decode_ctrl(w_next_state);
    end
  end

  // Instruction fetch completes in the same cycle memory signals ready.
  assign w_fetch_grant = (r_state == S_FETCH) && MemReady;

  assign PCWrite     = r_ctrl.pcwrite | w_fetch_grant;
  assign IRWrite     = w_fetch_grant;
  assign PCWriteCond = r_ctrl.pcwritecond;
  assign IorD        = r_ctrl.iord;
  assign MemRead     = r_ctrl.memread;
  assign MemWrite    = r_ctrl.memwrite;
  assign MemtoReg    = r_ctrl.memtoreg;
  assign RegDst      = r_ctrl.regdst;
  assign RegWrite    = r_ctrl.regwrite;
  assign ALUSrcA     = r_ctrl.alusrca;
  assign ALUSrcB     = r_ctrl.alusrcb;
  assign ALUop       = r_ctrl.aluop;
  assign PCSource    = r_ctrl.pcsource;
  assign State       = STATE_W'(r_state);
  assign FaultCode   = r_fault;

endmodule
